// File: rtl/sobolrng_multi_pkg.sv
// Shared types and helpers for the multi-dimension Sobol generator.
// Holds the FSM state type, the channel limit and the seek step-counter width.
package sobolrng_multi_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SEEK = 1'b1
    } state_t;

    localparam int unsigned MAX_DIMS = 8;

    function automatic int unsigned step_width(input int unsigned bw);
        return (bw > 1) ? $clog2(bw) : 1;
    endfunction

endpackage

// File: rtl/sobolrng_multi_lsz.sv
// One-hot least-significant zero of the sequence index.
// An all-ones index maps to the top bit so the Gray walk closes back to 0.
module sobol_lsz #(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] idx,
    output logic [BITWIDTH-1:0] onehot
);

    always_comb begin
        onehot = ~idx & (idx + BITWIDTH'(1));
        if (&idx) begin
            onehot = '0;
            onehot[BITWIDTH-1] = 1'b1;
        end
    end

endmodule

// File: rtl/sobolrng_multi.sv
// Multi-dimension Sobol RNG: one shared Gray-order index drives DIMS channels,
// with bit-serial skip-ahead, wrap pulse and busy/valid status.
module sobolrng_multi
    import sobolrng_multi_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned DIMS     = 2
) (
    input  logic                           iClk,
    input  logic                           iRstN,
    input  logic                           iEn,
    input  logic                           iClr,
    input  logic                           iSeek,
    input  logic [BITWIDTH-1:0]            iSeekIdx,
    input  logic [DIMS*BITWIDTH*BITWIDTH-1:0] iDirVec,
    output logic [DIMS*BITWIDTH-1:0]       oRand,
    output logic [BITWIDTH-1:0]            oIdx,
    output logic                           oValid,
    output logic                           oBusy,
    output logic                           oWrap
);

    localparam int unsigned SW = step_width(BITWIDTH);

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] idx_q;
    logic [BITWIDTH-1:0] seek_idx_q;
    logic [BITWIDTH-1:0] seek_g_q;
    logic [SW-1:0]       step_q;
    logic                wrap_q;
    logic                last_step;
    logic [BITWIDTH-1:0] lsz;

    sobol_lsz #(.BITWIDTH(BITWIDTH)) u_lsz (
        .idx    (idx_q),
        .onehot (lsz)
    );

    assign last_step = (step_q == SW'(BITWIDTH - 1));

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (iClr) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (iSeek) state_d = ST_SEEK;
                ST_SEEK: if (last_step) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            idx_q      <= '0;
            seek_idx_q <= '0;
            seek_g_q   <= '0;
            step_q     <= '0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (iClr) begin
                idx_q  <= '0;
                step_q <= '0;
            end else if (state_q == ST_RUN) begin
                if (iSeek) begin
                    seek_idx_q <= iSeekIdx;
                    seek_g_q   <= iSeekIdx ^ (iSeekIdx >> 1);
                    step_q     <= '0;
                end else if (iEn) begin
                    idx_q  <= idx_q + BITWIDTH'(1);
                    wrap_q <= &idx_q;
                end
            end else begin
                step_q <= step_q + SW'(1);
                if (last_step) begin
                    idx_q  <= seek_idx_q;
                    step_q <= '0;
                end
            end
        end
    end

    // The sample register doubles as the seek accumulator; oValid is low while it is partial.
    for (genvar d = 0; d < DIMS; d++) begin : g_ch
        logic [BITWIDTH-1:0] acc;
        logic [BITWIDTH-1:0] run_v;
        logic [BITWIDTH-1:0] seek_v;

        always_comb begin
            run_v  = '0;
            seek_v = '0;
            for (int unsigned k = 0; k < BITWIDTH; k++) begin
                run_v = run_v | ({BITWIDTH{lsz[k]}} & iDirVec[(d*BITWIDTH + k)*BITWIDTH +: BITWIDTH]);
                if (step_q == SW'(k) && seek_g_q[k])
                    seek_v = iDirVec[(d*BITWIDTH + k)*BITWIDTH +: BITWIDTH];
            end
        end

        always_ff @(posedge iClk or negedge iRstN) begin
            if (!iRstN) begin
                acc <= '0;
            end else if (iClr) begin
                acc <= '0;
            end else if (state_q == ST_RUN) begin
                if (iSeek)    acc <= '0;
                else if (iEn) acc <= acc ^ run_v;
            end else begin
                acc <= acc ^ seek_v;
            end
        end

        assign oRand[d*BITWIDTH +: BITWIDTH] = acc;
    end

    assign oIdx   = idx_q;
    assign oValid = (state_q == ST_RUN);
    assign oBusy  = (state_q == ST_SEEK);
    assign oWrap  = wrap_q;

endmodule
